// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: FSM states, requester ids and the
// read-data value returned with a timeout error response.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  localparam int unsigned ARB_ERR_RDATA = 0;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational fetch/data winner select.
// Ports: i_req_i, d_req_i (requests), last_i (previous owner, only
// with ARB_RR_EN), any_o (some request), win_o (winning requester).
// ARB_RR_EN defined: ties go to the requester that did not win last;
// otherwise data always wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic     i_req_i,
  input  logic     d_req_i,
`ifdef ARB_RR_EN
  input  arb_src_t last_i,
`endif
  output logic     any_o,
  output arb_src_t win_o
);

  always_comb begin
    any_o = i_req_i | d_req_i;
    win_o = SRC_D;
    unique case (1'b1)
      (i_req_i && !d_req_i): win_o = SRC_I;
`ifdef ARB_RR_EN
      (i_req_i && d_req_i && last_i == SRC_D): win_o = SRC_I;
`endif
      default: win_o = SRC_D;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (i_*) and data (d_*),
// one outstanding transaction, registered outputs, timeout watchdog.
// Ports: clk, rst (sync, active-low); i_req/i_addr -> i_gnt/i_rvalid/
// i_rdata/i_err; d_req/d_addr/d_we/d_wdata -> d_gnt/d_rvalid/d_rdata/
// d_err; mem_req/mem_addr/mem_we/mem_wdata <- mem_ready/mem_rvalid/
// mem_rdata; bus_err sticky timeout flag. Macro ARB_RR_EN: round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  arb_src_t          owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              gnt_q, gnt_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic              berr_q, berr_d;
  logic              any;
  arb_src_t          win;
  logic              done;
`ifdef ARB_RR_EN
  arb_src_t          last_q, last_d;
`endif

  arb_pick u_pick (
    .i_req_i (i_req),
    .d_req_i (d_req),
`ifdef ARB_RR_EN
    .last_i  (last_q),
`endif
    .any_o   (any),
    .win_o   (win)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= SRC_I;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      gnt_q   <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      berr_q  <= 1'b0;
`ifdef ARB_RR_EN
      last_q  <= SRC_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      berr_q  <= berr_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    req_d   = req_q;
    gnt_d   = 1'b0;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    berr_d  = berr_q;
    done    = 1'b0;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          state_d = ARB_ISSUE;
          owner_d = win;
          cnt_d   = '0;
          req_d   = 1'b1;
          gnt_d   = 1'b1;
`ifdef ARB_RR_EN
          last_d  = win;
`endif
          if (win == SRC_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            we_d    = '0;
            wdata_d = '0;
          end
        end
      end
      ARB_ISSUE: begin
        if (mem_ready) begin
          if (we_q != '0) begin
            done = 1'b1;
          end else begin
            state_d = ARB_WAIT;
            req_d   = 1'b0;
          end
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          done    = 1'b1;
          rdata_d = mem_rdata;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Watchdog; a completion in the last allowed cycle beats the timeout.
    if (state_q != ARB_IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (done || cnt_q == CNT_LAST) begin
        state_d = ARB_IDLE;
        req_d   = 1'b0;
        rv_d    = 1'b1;
        if (!done) begin
          err_d   = 1'b1;
          berr_d  = 1'b1;
          rdata_d = DATA_W'(ARB_ERR_RDATA);
        end
      end
    end
  end

  assign i_gnt     = gnt_q & (owner_q == SRC_I);
  assign d_gnt     = gnt_q & (owner_q == SRC_D);
  assign i_rvalid  = rv_q & (owner_q == SRC_I);
  assign d_rvalid  = rv_q & (owner_q == SRC_D);
  assign i_err     = err_q & (owner_q == SRC_I);
  assign d_err     = err_q & (owner_q == SRC_D);
  assign i_rdata   = (owner_q == SRC_I) ? rdata_q : '0;
  assign d_rdata   = (owner_q == SRC_D) ? rdata_q : '0;
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign bus_err   = berr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized traffic checked every cycle against a transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 64;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [BW-1:0] d_we;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, i_err;
  logic [DW-1:0] i_rdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          bus_err;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one owner at a time, age in cycles.
  bit            m_busy, m_acc, m_own_d, m_last_d, m_buserr;
  int            m_age;
  logic          e_igt, e_dgt, e_irv, e_drv, e_ierr, e_derr;
  logic          e_mreq, e_berr;
  logic [DW-1:0] e_rdata, e_wdata;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_we;

  task automatic respond(input bit err, input logic [DW-1:0] rd);
    m_busy  = 1'b0;
    e_mreq  = 1'b0;
    e_irv   = !m_own_d;
    e_drv   = m_own_d;
    e_ierr  = err && !m_own_d;
    e_derr  = err && m_own_d;
    e_rdata = rd;
    if (err) m_buserr = 1'b1;
  endtask

  task automatic model_step();
    bit            pick_d, fin;
    logic [DW-1:0] rd;
    e_igt = 0; e_dgt = 0; e_irv = 0; e_drv = 0;
    e_ierr = 0; e_derr = 0; e_rdata = '0;
    if (!rst) begin
      m_busy = 0; m_last_d = 0; m_buserr = 0;
      e_mreq = 0; e_addr = '0; e_we = '0; e_wdata = '0;
    end else if (!m_busy) begin
      if (i_req || d_req) begin
        pick_d = RR ? (d_req && !(i_req && m_last_d)) : d_req;
        m_busy = 1; m_acc = 0; m_age = 0;
        m_own_d = pick_d; m_last_d = pick_d;
        e_igt = !pick_d; e_dgt = pick_d; e_mreq = 1;
        e_addr  = pick_d ? d_addr : i_addr;
        e_we    = pick_d ? d_we : '0;
        e_wdata = pick_d ? d_wdata : '0;
      end
    end else begin
      fin = 0; rd = '0;
      if (!m_acc) begin
        if (mem_ready) begin
          if (e_we != '0) fin = 1;
          else begin m_acc = 1; e_mreq = 0; end
        end
      end else if (mem_rvalid) begin
        fin = 1; rd = mem_rdata;
      end
      if (fin) respond(1'b0, rd);
      else if (m_age == TO - 1) respond(1'b1, '0);
      else m_age++;
    end
    e_berr = m_buserr;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("i_gnt", i_gnt, e_igt);
    chk("d_gnt", d_gnt, e_dgt);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("i_err", i_err, e_ierr);
    chk("d_err", d_err, e_derr);
    chk("mem_req", mem_req, e_mreq);
    chk("bus_err", bus_err, e_berr);
    if (e_irv) chk("i_rdata", i_rdata, e_rdata);
    if (e_drv) chk("d_rdata", d_rdata, e_rdata);
    if (e_mreq) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  task automatic new_d();
    d_addr  = $urandom;
    d_we    = ($urandom_range(1, 0) == 1) ? BW'($urandom) : '0;
    d_wdata = $urandom;
  endtask

  initial begin
    int k;
    rst = 0; i_req = 1; d_req = 1;
    i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;

    // reset held with both requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_gnt", {i_gnt, d_gnt}, 0);
      chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
      chk("rst_bus_err", bus_err, 0);
    end
    rst = 1;
    k = 0;
    while (!d_gnt && !i_gnt && k < 4) begin @(negedge clk); k++; end
    chk("rst_first_gnt_d", d_gnt, 1);
    chk("rst_first_gnt_i", i_gnt, 0);
    chk("rst_gnt_delay_le2", (k >= 1 && k <= 2), 1);
    i_req = 0; d_req = 0;
    repeat (4) @(negedge clk);

    // zero-wait fetch
    i_addr = 32'h100; i_req = 1;
    @(negedge clk);
    chk("t2_i_gnt", i_gnt, 1);
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_we", mem_we, 0);
    i_req = 0;
    @(negedge clk);
    chk("t2_no_early_rvalid", i_rvalid, 0);
    @(negedge clk);
    chk("t2_i_rvalid", i_rvalid, 1);
    chk("t2_i_rdata", i_rdata, 32'hCAFEF00D);
    chk("t2_i_err", i_err, 0);
    repeat (2) @(negedge clk);

    // continuous contention
    i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h300; d_we = '0;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      do begin @(negedge clk); k++; end
      while (!i_gnt && !d_gnt && k < 10);
      chk("t3_gnt_seen", i_gnt | d_gnt, 1);
      chk("t3_winner_d", d_gnt, (RR && (g % 2 == 1)) ? 0 : 1);
    end
    i_req = 0; d_req = 0;
    repeat (4) @(negedge clk);

    // slow write, held request
    mem_ready = 0; d_addr = 32'h440; d_we = 4'b0011;
    d_wdata = 32'h1234; d_req = 1;
    @(negedge clk);
    chk("t4_d_gnt", d_gnt, 1);
    d_req = 0;
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_req", mem_req, 1);
      chk("t4_hold_addr", mem_addr, 32'h440);
      chk("t4_hold_wdata", mem_wdata, 32'h1234);
      chk("t4_hold_we", mem_we, 4'b0011);
      chk("t4_no_rvalid", d_rvalid, 0);
      if (c < 4) @(negedge clk);
    end
    mem_ready = 1;
    @(negedge clk);
    chk("t4_d_rvalid", d_rvalid, 1);
    chk("t4_d_err", d_err, 0);
    chk("t4_d_rdata", d_rdata, 0);
    chk("t4_mem_req_off", mem_req, 0);
    mem_ready = 0;
    @(negedge clk);
    chk("t4_rvalid_pulse", d_rvalid, 0);

    // memory never ready -> timeout
    d_addr = 32'h500; d_we = '0; d_req = 1;
    @(negedge clk);
    chk("t5_d_gnt", d_gnt, 1);
    d_req = 0;
    k = 0;
    while (!d_rvalid && k < 100) begin @(negedge clk); k++; end
    chk("t5_timeout_latency", k, TO);
    chk("t5_d_err", d_err, 1);
    chk("t5_d_rdata", d_rdata, 0);
    chk("t5_bus_err", bus_err, 1);
    mem_ready = 1;
    repeat (2) @(negedge clk);
    i_addr = 32'h600; i_req = 1;
    @(negedge clk);
    chk("t5_i_gnt", i_gnt, 1);
    i_req = 0;
    repeat (2) @(negedge clk);
    chk("t5_good_rvalid", i_rvalid, 1);
    chk("t5_good_err", i_err, 0);
    chk("t5_bus_err_sticky", bus_err, 1);

    // reset during WAIT, stale mem_rvalid afterwards
    repeat (2) @(negedge clk);
    mem_rvalid = 0; i_addr = 32'h700; i_req = 1;
    @(negedge clk);
    chk("t6_i_gnt", i_gnt, 1);
    i_req = 0;
    @(negedge clk);
    chk("t6_in_wait", mem_req, 0);
    rst = 0;
    @(negedge clk);
    rst = 1; mem_rvalid = 1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_rvalid", {i_rvalid, d_rvalid}, 0);
      chk("t6_mem_req", mem_req, 0);
    end
    chk("t6_bus_err_cleared", bus_err, 0);
    mem_rvalid = 0; mem_ready = 0;

    // randomized traffic
    for (int seg = 0; seg < 6; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 2) ? 2 : 60;
      repeat (500) begin
        @(negedge clk);
        if (i_gnt) begin
          if ($urandom_range(1, 0) == 1) i_addr = $urandom;
          else i_req = 0;
        end else if (!i_req && $urandom_range(3, 0) == 0) begin
          i_req = 1; i_addr = $urandom;
        end
        if (d_gnt) begin
          if ($urandom_range(1, 0) == 1) new_d();
          else d_req = 0;
        end else if (!d_req && $urandom_range(3, 0) == 0) begin
          d_req = 1; new_d();
        end
        mem_ready  = ($urandom_range(99, 0) < rdy_pct);
        mem_rvalid = ($urandom_range(1, 0) == 1);
        mem_rdata  = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
